// File: rtl/switch_setting_debouncer_pkg.sv
// switch_setting_debouncer_pkg: shared states, defaults and the zero-period check for the switch input stage.
package switch_setting_debouncer_pkg;
  localparam int DEF_N_SW = 8;
  localparam int DEF_STABLE_CYCLES = 240000;
  localparam logic [DEF_N_SW-1:0] DEF_RESET_VAL = 8'hEE;
  typedef logic [0:0] state_t;
  localparam state_t STABLE = 1'b0;
  localparam state_t SETTLING = 1'b1;
  // Both nibbles all-ones raw means m+n == 0 after inversion.
  function automatic logic is_zero_period(input logic [DEF_N_SW-1:0] bank);
    return (&bank[DEF_N_SW-1:DEF_N_SW/2]) && (&bank[DEF_N_SW/2-1:0]);
  endfunction
endpackage

// File: rtl/switch_setting_debouncer_if.sv
// switch_setting_debouncer_if: raw switch bank in, debounced bank plus update/busy out.
interface switch_setting_debouncer_if
  import switch_setting_debouncer_pkg::*;
#(parameter int N_SW = DEF_N_SW);
  logic [N_SW-1:0] sw;
  logic [N_SW-1:0] sw_out;
  logic update;
  logic busy;
  modport master (output sw, input sw_out, update, busy);
  modport slave (input sw, output sw_out, update, busy);
endinterface

// File: rtl/switch_setting_debouncer_sync_2ff.sv
// sync_2ff: two-flop synchroniser with async active-low reset to a chosen value.
module sync_2ff #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sync1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= RST_VAL;
      q <= RST_VAL;
    end else begin
      sync1 <= d;
      q <= sync1;
    end
endmodule

// File: rtl/switch_setting_debouncer.sv
// switch_setting_debouncer: synchronise and debounce the DIP bank, commit with a one-cycle update strobe.
// Define ZERO_PERIOD_GUARD_EN to reject banks whose ON and OFF nibbles are both all-ones.
module switch_setting_debouncer
  import switch_setting_debouncer_pkg::*;
#(
  parameter int N_SW = DEF_N_SW,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W = 18,
  parameter logic [N_SW-1:0] RESET_VAL = DEF_RESET_VAL
) (
  input logic clk,
  input logic reset_n,
  switch_setting_debouncer_if.slave bus
);
  logic [N_SW-1:0] sync2, cand, sw_q;
  logic [CNT_W-1:0] cnt;
  state_t state;
  logic upd_q, start, done;
  sync_2ff #(.W(N_SW), .RST_VAL(RESET_VAL)) u_sync (.clk(clk), .reset_n(reset_n), .d(bus.sw), .q(sync2));
`ifdef ZERO_PERIOD_GUARD_EN
  logic [N_SW-1:0] rejected;
  assign start = (sync2 != sw_q) && (sync2 != rejected);
`else
  assign start = sync2 != sw_q;
`endif
  assign done = cnt == CNT_W'(STABLE_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= STABLE;
      cnt <= '0;
      cand <= RESET_VAL;
      sw_q <= RESET_VAL;
      upd_q <= 1'b0;
`ifdef ZERO_PERIOD_GUARD_EN
      rejected <= RESET_VAL;
`endif
    end else begin
      upd_q <= 1'b0;
      if (state == STABLE) begin
        if (start) begin
          cand <= sync2;
          cnt <= '0;
          state <= SETTLING;
        end
      end else if (sync2 != cand) begin
        cand <= sync2;
        cnt <= '0;
      end else if (done) begin
        state <= STABLE;
        cnt <= '0;
`ifdef ZERO_PERIOD_GUARD_EN
        if (is_zero_period(cand)) rejected <= cand;
        else if (cand != sw_q) begin
          sw_q <= cand;
          upd_q <= 1'b1;
        end
`else
        if (cand != sw_q) begin
          sw_q <= cand;
          upd_q <= 1'b1;
        end
`endif
      end else cnt <= cnt + CNT_W'(1);
    end
  assign bus.sw_out = sw_q;
  assign bus.update = upd_q;
  assign bus.busy = state == SETTLING;
endmodule

// File: tb/tb_switch_setting_debouncer.sv
// tb_switch_setting_debouncer: directed checks of debounce timing, bounce, glitch, async reset and 8'hFF.
module tb_switch_setting_debouncer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;
  bit saw_busy;
  switch_setting_debouncer_if #(.N_SW(8)) bus ();
  switch_setting_debouncer #(.N_SW(8), .STABLE_CYCLES(4), .CNT_W(3), .RESET_VAL(8'hEE))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Edge 1 is the first edge sampling the new bank; commit lands on edge 7.
  task automatic wait_commit(input logic [7:0] old_v, input logic [7:0] new_v, input logic exp_upd);
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk($sformatf("hold_sw_out_e%0d", n), bus.sw_out, old_v);
      chk($sformatf("hold_update_e%0d", n), bus.update, 1'b0);
      if (n >= 3) chk($sformatf("busy_e%0d", n), bus.busy, 1'b1);
    end
    tick();
    chk("commit_sw_out", bus.sw_out, new_v);
    chk("commit_update", bus.update, exp_upd);
    chk("commit_busy", bus.busy, 1'b0);
    tick();
    chk("update_one_cycle", bus.update, 1'b0);
  endtask
  initial begin
    bus.sw = 8'h00;
    #12;
    chk("rst_sw_out", bus.sw_out, 8'hEE);
    chk("rst_update", bus.update, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_commit(8'hEE, 8'h00, 1'b1);
    @(negedge clk);
    bus.sw = 8'h35;
    wait_commit(8'h00, 8'h35, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.sw = i[0] ? 8'h35 : 8'h34;
      for (int j = 0; j < 2; j++) begin
        tick();
        chk("bounce_update", bus.update, 1'b0);
        chk("bounce_sw_out", bus.sw_out, 8'h35);
      end
    end
    @(negedge clk);
    bus.sw = 8'h34;
    wait_commit(8'h35, 8'h34, 1'b1);
    @(negedge clk);
    bus.sw = 8'h14;
    saw_busy = 1'b0;
    for (int n = 0; n < 14; n++) begin
      if (n == 2) begin
        @(negedge clk);
        bus.sw = 8'h34;
      end
      tick();
      saw_busy |= bus.busy;
      chk("glitch_update", bus.update, 1'b0);
      chk("glitch_sw_out", bus.sw_out, 8'h34);
    end
    chk("glitch_saw_busy", saw_busy, 1'b1);
    chk("glitch_busy_end", bus.busy, 1'b0);
    @(negedge clk);
    bus.sw = 8'h5A;
    for (int n = 0; n < 4; n++) tick();
    chk("pre_reset_busy", bus.busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_sw_out", bus.sw_out, 8'hEE);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_update", bus.update, 1'b0);
    #8;
    reset_n = 1'b1;
    wait_commit(8'hEE, 8'h5A, 1'b1);
    @(negedge clk);
    bus.sw = 8'hFF;
`ifdef ZERO_PERIOD_GUARD_EN
    wait_commit(8'h5A, 8'h5A, 1'b0);
`else
    wait_commit(8'h5A, 8'hFF, 1'b1);
`endif
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("ff_busy_once", bus.busy, 1'b0);
      chk("ff_no_update", bus.update, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
